// File: rtl/four_bit_serial_pkg.sv
// rtl/four_bit_serial_pkg.sv - shared state and command encodings for the serial add/subtract blocks
package four_bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } serial_state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_SHIFT = 2'b01;
    localparam logic [1:0] SEL_CLEAR = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - WIDTH-bit register with parallel load, clear and right shift with serial-in
module serial_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/four_bit_serial_add.sv
// rtl/four_bit_serial_add.sv - LSB-first bit-serial adder with control FSM; SERIAL_ADD_OVF_EN adds signed overflow
module four_bit_serial_add
    import four_bit_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] shift_reg_A_out,
    output logic [WIDTH-1:0] shift_reg_B_out,
    output logic             Q,
    output logic             Sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    serial_state_t state;
    logic [CW-1:0] count;
    logic          do_load;
    logic          do_clear;
    logic          do_shift;
    logic          carry;

    assign do_load  = (sel == SEL_LOAD);
    assign do_clear = (sel == SEL_CLEAR);
    assign do_shift = (sel == SEL_SHIFT) && (state == READY || state == RUN);

    assign Sum   = shift_reg_A_out[0] ^ shift_reg_B_out[0] ^ Q;
    assign carry = (shift_reg_A_out[0] & shift_reg_B_out[0])
                 | (Q & (shift_reg_A_out[0] ^ shift_reg_B_out[0]));
    assign cout  = (state == DONE) ? Q : 1'b0;

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (do_load),
        .clear (do_clear),
        .shift (do_shift),
        .sin   (Sum),
        .din   (a_in),
        .q     (shift_reg_A_out)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (do_load),
        .clear (do_clear),
        .shift (do_shift),
        .sin   (SI),
        .din   (b_in),
        .q     (shift_reg_B_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            Q     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (do_load) begin
                state <= READY;
                count <= '0;
                Q     <= 1'b0;
                busy  <= 1'b1;
            end else if (do_clear) begin
                state <= IDLE;
                count <= '0;
                Q     <= 1'b0;
                busy  <= 1'b0;
            end else if (do_shift) begin
                Q     <= carry;
                count <= count + 1'b1;
                if (count == LAST_STEP) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB is the carry flop just before the final step.
    logic msb_cin;

    always_ff @(posedge clk) begin
        if (rst || do_load || do_clear) begin
            msb_cin <= 1'b0;
        end else if (do_shift && count == LAST_STEP) begin
            msb_cin <= Q;
        end
    end

    assign ovf = (state == DONE) ? (msb_cin ^ Q) : 1'b0;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_serial_add.sv
// tb/tb_four_bit_serial_add.sv - directed self-checking bench for four_bit_serial_add
module tb_four_bit_serial_add;
    import four_bit_serial_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       SI;
    logic [1:0] sel;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] shift_reg_A_out;
    logic [3:0] shift_reg_B_out;
    logic       Q;
    logic       Sum;
    logic       cout;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SERIAL_ADD_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    four_bit_serial_add #(.WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .SI              (SI),
        .sel             (sel),
        .a_in            (a_in),
        .b_in            (b_in),
        .shift_reg_A_out (shift_reg_A_out),
        .shift_reg_B_out (shift_reg_B_out),
        .Q               (Q),
        .Sum             (Sum),
        .cout            (cout),
        .ovf             (ovf),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [1:0] s, input logic si);
        sel = s;
        SI  = si;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {18'd0, shift_reg_A_out, shift_reg_B_out, Q, Sum, cout, ovf, busy, done};
    endfunction

    initial begin
        rst  = 1'b1;
        sel  = SEL_HOLD;
        SI   = 1'b1;
        a_in = 4'b1111;
        b_in = 4'b1111;

        // reset overrides every command
        step(SEL_HOLD, 1'b1);
        chk("rst_sel00", all_outs(), 32'd0);
        step(SEL_SHIFT, 1'b1);
        chk("rst_sel01", all_outs(), 32'd0);
        step(SEL_CLEAR, 1'b1);
        chk("rst_sel10", all_outs(), 32'd0);
        step(SEL_LOAD, 1'b1);
        chk("rst_sel11", all_outs(), 32'd0);
        rst = 1'b0;

        // scenario 1: 0101 + 0011, SI pattern 1,0,1,1
        a_in = 4'b0101;
        b_in = 4'b0011;
        step(SEL_LOAD, 1'b0);
        chk("s1_load_a", shift_reg_A_out, 4'b0101);
        chk("s1_load_b", shift_reg_B_out, 4'b0011);
        chk("s1_load_busy", busy, 1'b1);
        chk("s1_load_sum", Sum, 1'b0);
        step(SEL_SHIFT, 1'b1);
        chk("s1_st1_a", shift_reg_A_out, 4'b0010);
        chk("s1_st1_q", Q, 1'b1);
        step(SEL_SHIFT, 1'b0);
        step(SEL_SHIFT, 1'b1);
        chk("s1_st3_done", done, 1'b0);
        chk("s1_st3_busy", busy, 1'b1);
        step(SEL_SHIFT, 1'b1);
        chk("s1_a", shift_reg_A_out, 4'b1000);
        chk("s1_b", shift_reg_B_out, 4'b1101);
        chk("s1_cout", cout, 1'b0);
        chk("s1_done", done, 1'b1);
        chk("s1_busy", busy, 1'b0);
        chk("s1_ovf", ovf, OVF_ON);
        step(SEL_HOLD, 1'b0);
        chk("s1_done_pulse", done, 1'b0);
        chk("s1_hold_a", shift_reg_A_out, 4'b1000);

        // shifts after DONE are ignored
        step(SEL_SHIFT, 1'b0);
        chk("s5_done1", done, 1'b0);
        step(SEL_SHIFT, 1'b0);
        chk("s5_done2", done, 1'b0);
        chk("s5_a", shift_reg_A_out, 4'b1000);
        chk("s5_b", shift_reg_B_out, 4'b1101);

        // scenario 2: 1111 + 0001 wraps with carry-out
        a_in = 4'b1111;
        b_in = 4'b0001;
        step(SEL_LOAD, 1'b0);
        repeat (4) step(SEL_SHIFT, 1'b0);
        chk("s2_a", shift_reg_A_out, 4'b0000);
        chk("s2_cout", cout, 1'b1);
        chk("s2_done", done, 1'b1);
        chk("s2_ovf", ovf, 1'b0);

        // scenario 3: 0110 + 0111 with holds in the middle
        a_in = 4'b0110;
        b_in = 4'b0111;
        step(SEL_LOAD, 1'b0);
        step(SEL_SHIFT, 1'b0);
        step(SEL_SHIFT, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(SEL_HOLD, 1'b0);
            chk("s3_hold_a", shift_reg_A_out, 4'b0101);
            chk("s3_hold_q", Q, 1'b1);
            chk("s3_hold_done", done, 1'b0);
        end
        step(SEL_SHIFT, 1'b0);
        chk("s3_st3_done", done, 1'b0);
        step(SEL_SHIFT, 1'b0);
        chk("s3_a", shift_reg_A_out, 4'b1101);
        chk("s3_cout", cout, 1'b0);
        chk("s3_done", done, 1'b1);
        chk("s3_ovf", ovf, OVF_ON);

        // scenario 4: reset mid-operation, then a stray shift
        a_in = 4'b0101;
        b_in = 4'b0011;
        step(SEL_LOAD, 1'b0);
        step(SEL_SHIFT, 1'b0);
        step(SEL_SHIFT, 1'b0);
        rst = 1'b1;
        step(SEL_SHIFT, 1'b1);
        chk("s4_rst", all_outs(), 32'd0);
        rst = 1'b0;
        step(SEL_SHIFT, 1'b1);
        chk("s4_idle_shift", all_outs(), 32'd0);

        // load mid-run restarts with the new operands
        a_in = 4'b0001;
        b_in = 4'b0001;
        step(SEL_LOAD, 1'b0);
        step(SEL_SHIFT, 1'b0);
        a_in = 4'b0010;
        b_in = 4'b0011;
        step(SEL_LOAD, 1'b0);
        chk("rl_q", Q, 1'b0);
        repeat (3) step(SEL_SHIFT, 1'b0);
        chk("rl_st3_done", done, 1'b0);
        step(SEL_SHIFT, 1'b0);
        chk("rl_a", shift_reg_A_out, 4'b0101);
        chk("rl_done", done, 1'b1);

        // clear mid-run
        a_in = 4'b1011;
        b_in = 4'b0110;
        step(SEL_LOAD, 1'b0);
        step(SEL_SHIFT, 1'b0);
        step(SEL_CLEAR, 1'b0);
        chk("clr", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
